// File: rtl/alu_mc_pkg.sv
// Shared opcodes, FSM state type and counter sizing for the multi-cycle ALU.
// The divider is built only when ALU_MC_DIV_EN is defined.
package alu_mc_pkg;

  localparam logic [3:0] ALU_AND  = 4'd0;
  localparam logic [3:0] ALU_OR   = 4'd1;
  localparam logic [3:0] ALU_ADD  = 4'd2;
  localparam logic [3:0] ALU_SUB  = 4'd3;
  localparam logic [3:0] ALU_SLT  = 4'd4;
  localparam logic [3:0] ALU_NOR  = 4'd5;
  localparam logic [3:0] ALU_XOR  = 4'd6;
  localparam logic [3:0] ALU_SLL  = 4'd7;
  localparam logic [3:0] ALU_SRL  = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd9;
  localparam logic [3:0] ALU_MULU = 4'd10;
  localparam logic [3:0] ALU_DIVU = 4'd11;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic int iter_cnt_w(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/alu_mc_iter.sv
// Iterative datapath shared by shift-add multiply and restoring divide.
// The restoring-divide step exists only when ALU_MC_DIV_EN is defined.
module alu_mc_iter
  import alu_mc_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             step_i,
  input  logic             div_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] lo_next_o,
  output logic [WIDTH-1:0] hi_next_o,
  output logic             last_o
);

  localparam int CW = iter_cnt_w(WIDTH);

  logic [WIDTH-1:0] lo_q, hi_q, b_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH:0]   sum;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lo_q  <= '0;
      hi_q  <= '0;
      b_q   <= '0;
      cnt_q <= '0;
    end else if (load_i) begin
      lo_q  <= a_i;
      hi_q  <= '0;
      b_q   <= b_i;
      cnt_q <= '0;
    end else if (step_i) begin
      lo_q  <= lo_next_o;
      hi_q  <= hi_next_o;
      cnt_q <= cnt_q + 1'b1;
    end
  end

`ifdef ALU_MC_DIV_EN
  logic           div_q;
  logic [WIDTH:0] tmp, diff;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)       div_q <= 1'b0;
    else if (load_i) div_q <= div_i;
  end
`else
  logic unused_div;
  assign unused_div = div_i;
`endif

  always_comb begin
    // Multiply: {hi,lo} shifts right while the multiplier drains out of lo.
    sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    {hi_next_o, lo_next_o} = {sum, lo_q[WIDTH-1:1]};
`ifdef ALU_MC_DIV_EN
    tmp  = {hi_q, lo_q[WIDTH-1]};
    diff = tmp - {1'b0, b_q};
    if (div_q) begin
      // With b = 0 every trial succeeds: quotient all ones, remainder = dividend.
      if (tmp >= {1'b0, b_q}) begin
        hi_next_o = diff[WIDTH-1:0];
        lo_next_o = {lo_q[WIDTH-2:0], 1'b1};
      end else begin
        hi_next_o = tmp[WIDTH-1:0];
        lo_next_o = {lo_q[WIDTH-2:0], 1'b0};
      end
    end
`endif
  end

  assign last_o = step_i && (cnt_q == CW'(WIDTH - 1));

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/arith/shift ops, iterative MULU/DIVU.
// Define ALU_MC_DIV_EN to build DIVU; otherwise code 11 is reserved and DZ is 0.
module alu_mc
  import alu_mc_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Start,
  input  logic [WIDTH-1:0] OP1,
  input  logic [WIDTH-1:0] OP2,
  input  logic [3:0]       ALUSel,
  output logic [WIDTH-1:0] Res,
  output logic [WIDTH-1:0] ResHi,
  output logic             Z,
  output logic             Busy,
  output logic             Done,
  output logic             Err,
  output logic             DZ,
  output state_t           dbg_state_o
);

  localparam int SW = $clog2(WIDTH);
`ifdef ALU_MC_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  // Handshake: Start is sampled only while Busy=0; Done pulses for one cycle
  // when Res/ResHi/Z/Err/DZ change, and those outputs hold until the next Done.
  state_t           state_q, state_d;
  logic [WIDTH-1:0] res_q, res_d, reshi_q, reshi_d;
  logic             err_q, err_d, dz_q, dz_d, done_q, done_d, dzp_q, dzp_d;

  logic [WIDTH-1:0] sc_res, lo_next, hi_next;
  logic [SW-1:0]    shamt;
  logic             sc_err, is_mul, is_div, load, step, last;

  assign shamt  = OP2[SW-1:0];
  assign is_mul = (ALUSel == ALU_MULU);
  assign is_div = DIV_EN && (ALUSel == ALU_DIVU);

  always_comb begin
    sc_res = '0;
    sc_err = 1'b0;
    case (ALUSel)
      ALU_AND: sc_res = OP1 & OP2;
      ALU_OR:  sc_res = OP1 | OP2;
      ALU_ADD: sc_res = OP1 + OP2;
      ALU_SUB: sc_res = OP1 - OP2;
      ALU_SLT: sc_res = {{(WIDTH-1){1'b0}}, ($signed(OP1) < $signed(OP2))};
      ALU_NOR: sc_res = ~(OP1 | OP2);
      ALU_XOR: sc_res = OP1 ^ OP2;
      ALU_SLL: sc_res = OP1 << shamt;
      ALU_SRL: sc_res = OP1 >> shamt;
      ALU_SRA: sc_res = $unsigned($signed(OP1) >>> shamt);
      default: sc_err = !(is_mul || is_div);
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      res_q   <= '0;
      reshi_q <= '0;
      err_q   <= 1'b0;
      dz_q    <= 1'b0;
      done_q  <= 1'b0;
      dzp_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      reshi_q <= reshi_d;
      err_q   <= err_d;
      dz_q    <= dz_d;
      done_q  <= done_d;
      dzp_q   <= dzp_d;
    end
  end

  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    reshi_d = reshi_q;
    err_d   = err_q;
    dz_d    = dz_q;
    dzp_d   = dzp_q;
    done_d  = 1'b0;
    load    = 1'b0;
    step    = 1'b0;
    case (state_q)
      IDLE: begin
        if (Start) begin
          if (is_mul || is_div) begin
            load    = 1'b1;
            state_d = RUN;
            dzp_d   = is_div && (OP2 == '0);
          end else begin
            res_d   = sc_res;
            reshi_d = '0;
            err_d   = sc_err;
            dz_d    = 1'b0;
            done_d  = 1'b1;
          end
        end
      end
      RUN: begin
        step = 1'b1;
        if (last) begin
          state_d = IDLE;
          res_d   = lo_next;
          reshi_d = hi_next;
          err_d   = 1'b0;
          dz_d    = dzp_q;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  alu_mc_iter #(.WIDTH(WIDTH)) u_iter (
    .clk_i     (CLK),
    .rst_i     (RST),
    .load_i    (load),
    .step_i    (step),
    .div_i     (is_div),
    .a_i       (OP1),
    .b_i       (OP2),
    .lo_next_o (lo_next),
    .hi_next_o (hi_next),
    .last_o    (last)
  );

  assign Res         = res_q;
  assign ResHi       = reshi_q;
  assign Z           = (res_q == '0);
  assign Busy        = (state_q == RUN);
  assign Done        = done_q;
  assign Err         = err_q;
  assign DZ          = dz_q;
  assign dbg_state_o = state_q;

endmodule
